// File: rtl/if_id_skid_if.sv
// Fetch-to-decode handshake bundle for the IF/ID skid buffer.
// master = fetch/decode side, slave = the buffer itself.
interface if_id_skid_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc4;
  logic [5:0]  out_opcode;
  logic [15:0] out_imm16;
  logic [1:0]  out_count;

  modport master (
    output in_valid,
    output in_instr,
    output in_pc,
    output flush,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_instr,
    input  out_pc4,
    input  out_opcode,
    input  out_imm16,
    input  out_count
  );

  modport slave (
    input  in_valid,
    input  in_instr,
    input  in_pc,
    input  flush,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_instr,
    output out_pc4,
    output out_opcode,
    output out_imm16,
    output out_count
  );
endinterface

// File: rtl/if_id_skid.sv
// IF/ID skid buffer: 2-entry in-order FIFO of {instr, pc+4}.
// Slot 0 is always the head; outputs read zero when empty.
module if_id_skid (
  input  logic         clk,
  input  logic         reset_n,
  if_id_skid_if.slave  bus
);

  logic [31:0] r_instr [2];
  logic [31:0] r_pc4   [2];
  logic [1:0]  r_count;

  logic        w_in_ready;
  logic        w_out_valid;
  logic        w_push;
  logic        w_pop;
  logic        w_slot;
  logic [31:0] w_head_instr;
  logic [31:0] w_head_pc4;

  assign w_in_ready  = (r_count < 2'd2) & reset_n;
  assign w_out_valid = (r_count != 2'd0);
  assign w_push      = bus.in_valid & w_in_ready & ~bus.flush;
  assign w_pop       = w_out_valid & bus.out_ready & ~bus.flush;

  // A simultaneous pop shifts slot 1 down, so the new entry lands one lower.
  assign w_slot = r_count[0] & ~w_pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count    <= 2'd0;
      r_instr[0] <= '0;
      r_instr[1] <= '0;
      r_pc4[0]   <= '0;
      r_pc4[1]   <= '0;
    end else if (bus.flush) begin
      r_count <= 2'd0;
    end else begin
      if (w_pop) begin
        r_instr[0] <= r_instr[1];
        r_pc4[0]   <= r_pc4[1];
      end
      if (w_push) begin
        r_instr[w_slot] <= bus.in_instr;
        r_pc4[w_slot]   <= bus.in_pc + 32'd4;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  // Gate on valid so stale slot contents never leak out.
  assign w_head_instr = w_out_valid ? r_instr[0] : '0;
  assign w_head_pc4   = w_out_valid ? r_pc4[0]   : '0;

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = w_out_valid;
  assign bus.out_instr  = w_head_instr;
  assign bus.out_pc4    = w_head_pc4;
  assign bus.out_opcode = w_head_instr[31:26];
  assign bus.out_imm16  = w_head_instr[15:0];
  assign bus.out_count  = r_count;

endmodule

// File: tb/tb_if_id_skid.sv
// Self-checking bench for if_id_skid: queue reference model,
// directed scenarios plus randomized traffic.
module tb_if_id_skid;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } ent_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  ent_t sb[$];

  always #5 clk = ~clk;

  if_id_skid_if bus();

  if_id_skid dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference model: a plain queue updated by the handshake rules.
  always @(posedge clk) begin : predictor
    bit pop;
    bit push;
    if (reset_n) begin
      pop  = (sb.size() != 0) && bus.out_ready && !bus.flush;
      push = bus.in_valid && (sb.size() < 2) && !bus.flush;
      if (bus.flush) begin
        sb.delete();
      end else begin
        if (pop) void'(sb.pop_front());
        if (push) sb.push_back('{bus.in_instr, bus.in_pc + 32'd4});
      end
    end
  end

  always @(negedge reset_n) sb.delete();

  // Monitor: compare the presented head against the model every cycle.
  always @(negedge clk) begin : monitor
    logic [31:0] ei;
    logic [31:0] ep;
    ei = '0;
    ep = '0;
    if (sb.size() != 0) begin
      ei = sb[0].instr;
      ep = sb[0].pc4;
    end
    chk("mon_count", {30'd0, bus.out_count}, sb.size());
    chk("mon_valid", {31'd0, bus.out_valid}, {31'd0, sb.size() != 0});
    chk("mon_ready", {31'd0, bus.in_ready},
        {31'd0, reset_n && (sb.size() < 2)});
    chk("mon_instr", bus.out_instr, ei);
    chk("mon_pc4", bus.out_pc4, ep);
    chk("mon_opcode", {26'd0, bus.out_opcode}, {26'd0, ei[31:26]});
    chk("mon_imm16", {16'd0, bus.out_imm16}, {16'd0, ei[15:0]});
  end

  task automatic check_zero(input string nm);
    chk({nm, "_valid"}, {31'd0, bus.out_valid}, 32'd0);
    chk({nm, "_ready"}, {31'd0, bus.in_ready}, 32'd0);
    chk({nm, "_count"}, {30'd0, bus.out_count}, 32'd0);
    chk({nm, "_instr"}, bus.out_instr, 32'd0);
    chk({nm, "_pc4"}, bus.out_pc4, 32'd0);
    chk({nm, "_op"}, {26'd0, bus.out_opcode}, 32'd0);
    chk({nm, "_imm"}, {16'd0, bus.out_imm16}, 32'd0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_instr  = '0;
    bus.in_pc     = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;

    #2;
    check_zero("rst_hold");
    cyc();
    cyc();
    #2;
    reset_n = 1'b1;
    #1;
    chk("rst_rel_ready", {31'd0, bus.in_ready}, 32'd1);
    cyc();

    // Single push, one-cycle latency
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h3C01ABCD;
    bus.in_pc    = 32'h00000040;
    cyc();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("single_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("single_instr", bus.out_instr, 32'h3C01ABCD);
    chk("single_op", {26'd0, bus.out_opcode}, 32'h0F);
    chk("single_imm", {16'd0, bus.out_imm16}, 32'hABCD);
    chk("single_pc4", bus.out_pc4, 32'h00000044);
    chk("single_cnt", {30'd0, bus.out_count}, 32'd1);
    bus.out_ready = 1'b1;
    cyc();
    bus.out_ready = 1'b0;

    // Backpressure
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h11111111;
    cyc();
    bus.in_instr = 32'h22222222;
    cyc();
    bus.in_instr = 32'h33333333;
    cyc();
    cyc();
    @(negedge clk);
    chk("bp_cnt", {30'd0, bus.out_count}, 32'd2);
    chk("bp_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("bp_head", bus.out_instr, 32'h11111111);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    cyc();
    @(negedge clk);
    chk("bp_head2", bus.out_instr, 32'h22222222);
    cyc();
    @(negedge clk);
    chk("bp_empty_cnt", {30'd0, bus.out_count}, 32'd0);
    chk("bp_empty_instr", bus.out_instr, 32'd0);
    chk("bp_empty_pc4", bus.out_pc4, 32'd0);
    bus.out_ready = 1'b0;

    // Steady stream
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.in_instr = 32'hA0000000 + i;
      bus.in_pc    = 32'h00001000 + 4 * i;
      cyc();
      @(negedge clk);
      chk("stream_cnt", {30'd0, bus.out_count}, 32'd1);
      chk("stream_head", bus.out_instr, 32'hA0000000 + i);
    end
    bus.in_valid = 1'b0;
    cyc();
    bus.out_ready = 1'b0;

    // Flush at full with a competing offer
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h12340001;
    cyc();
    bus.in_instr = 32'h12340002;
    cyc();
    bus.in_instr = 32'hDEADBEEF;
    bus.flush    = 1'b1;
    cyc();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("flush_cnt", {30'd0, bus.out_count}, 32'd0);
    chk("flush_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("flush_instr", bus.out_instr, 32'd0);
    cyc();
    @(negedge clk);
    chk("flush_drop", bus.out_instr, 32'd0);

    // PC wrap, then asynchronous reset mid-cycle
    bus.in_valid = 1'b1;
    bus.in_instr = 32'h0BADF00D;
    bus.in_pc    = 32'hFFFFFFFC;
    cyc();
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("wrap_pc4", bus.out_pc4, 32'h00000000);
    chk("wrap_valid", {31'd0, bus.out_valid}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_zero("async_rst");
    bus.in_valid = 1'b1;
    cyc();
    chk("rst_ready_low", {31'd0, bus.in_ready}, 32'd0);
    #3;
    reset_n = 1'b1;
    #1;
    chk("rst_ready_hi", {31'd0, bus.in_ready}, 32'd1);
    bus.in_valid = 1'b0;
    cyc();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      bus.in_valid  = ($urandom % 4) != 0;
      bus.out_ready = ($urandom % 3) != 0;
      bus.flush     = ($urandom % 25) == 0;
      bus.in_instr  = $urandom;
      bus.in_pc     = (($urandom % 16) == 0) ? 32'hFFFFFFFC
                                              : ($urandom & 32'hFFFFFFFC);
      cyc();
      if (i == 300) begin
        #2;
        reset_n = 1'b0;
        #1;
        check_zero("rand_rst");
        cyc();
        #2;
        reset_n = 1'b1;
        cyc();
      end
    end
    bus.in_valid  = 1'b0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    cyc();
    cyc();
    cyc();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_id_skid.md
IF_ID_SKID -- requirements
Module: if_id_skid

Parameters
REQ-001 The block SHALL have no parameters; all widths are fixed at 32-bit instruction/PC and 16-bit immediate.

Interface
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  fetch presents an instruction this cycle.
REQ-005 in_ready  output  1  block can accept an instruction this cycle.
REQ-006 in_instr  input  32  fetched instruction word.
REQ-007 in_pc  input  32  address of the fetched instruction.
REQ-008 flush  input  1  discard all held instructions (branch/jump taken).
REQ-009 out_valid  output  1  head entry is valid for decode.
REQ-010 out_ready  input  1  decode consumes the head entry this cycle.
REQ-011 out_instr  output  32  head instruction word.
REQ-012 out_pc4  output  32  head instruction address plus 4.
REQ-013 out_opcode  output  6  out_instr[31:26].
REQ-014 out_imm16  output  16  out_instr[15:0]; drives the 16-bit input of the decode-stage zero/sign extenders.
REQ-015 out_count  output  2  number of held entries (0..2).

Function
REQ-016 The block SHALL be a 2-entry in-order FIFO (skid buffer) between fetch and decode.
- Each entry holds {instr, pc4}.
REQ-017 Push: occurs when in_valid=1 and in_ready=1 and flush=0.
- Stores in_instr and in_pc+4, wrapping modulo 2^32; 0xFFFFFFFC yields 0x00000000.
REQ-018 in_ready SHALL equal (out_count<2) AND reset_n.
- Registered-state function only; no combinational path from out_ready or in_valid.
REQ-019 out_valid SHALL equal (out_count!=0).
REQ-020 Pop: occurs when out_valid=1, out_ready=1 and flush=0.
- Removes the head entry; the next entry, if any, becomes head on the following cycle.
REQ-021 Outputs SHALL always reflect the current head entry.
- When out_count=0: out_instr, out_pc4, out_opcode and out_imm16 SHALL be all zeros (NOP); stale data SHALL never be visible.
REQ-022 Simultaneous push and pop:
- At count=1: count stays 1; the new entry becomes head next cycle.
- At count=0: pop cannot occur (out_valid=0); count goes to 1.
REQ-023 At count=2, in_ready=0 and in_valid is ignored; a pop reduces count to 1.
REQ-024 Latency:
- An instruction pushed into an empty block SHALL appear on the outputs with out_valid=1 exactly one cycle after the push edge.
- No bypass path exists.
REQ-025 flush=1 has priority over push and pop.
- On the edge it is sampled: count goes to 0, all entries are discarded, and the in_instr offered that cycle is dropped.
- Outputs read zeros from the next cycle.
REQ-026 out_instr, out_opcode and out_imm16 SHALL be bit-exact slices of the same head entry; they SHALL never be mixed from different entries.
REQ-027 Ordering SHALL be strict FIFO; no entry is duplicated or lost except by flush or reset.

Reset
REQ-028 While reset_n=0, the block SHALL hold: out_count=0, out_valid=0, in_ready=0, out_instr=0, out_pc4=0, out_opcode=0, out_imm16=0.
REQ-029 Asserting reset_n low mid-operation SHALL clear all entries immediately, without waiting for a clock edge.
REQ-030 After reset_n rises, the first rising edge with in_valid=1 SHALL push normally; in_ready=1 from deassertion.

Verification
REQ-031 Single push: push instr=0x3C01ABCD, pc=0x00000040 into an empty block -> next cycle:
- out_valid=1, out_instr=0x3C01ABCD, out_opcode=0x0F, out_imm16=0xABCD, out_pc4=0x00000044, out_count=1.
REQ-032 Backpressure: out_ready=0; push 0x11111111 then 0x22222222 -> count=2, in_ready=0; a third offer of 0x33333333 is not accepted.
- Then out_ready=1 for 2 cycles -> 0x11111111 popped, then 0x22222222 popped; count=0; outputs read zero.
REQ-033 Steady stream: in_valid=1 and out_ready=1 every cycle for 8 instructions -> one pop per cycle after the first, count stays 1, order preserved, no drops.
REQ-034 Flush: count=2 with in_valid=1 and flush=1 on one edge -> count=0, out_valid=0, out_instr=0 next cycle; the offered instruction never appears at the outputs.
REQ-035 Wrap and reset: push pc=0xFFFFFFFC -> out_pc4=0x00000000.
- Then pull reset_n low between edges -> all outputs zero immediately; in_ready=0 until reset_n rises.
